// File: rtl/rice_core_pkg.sv
// rtl/rice_core_pkg.sv - shared types and helpers for the divider and its controller
package rice_core_pkg;

  localparam int XLEN = 32;

  // One-hot M-extension divide/remainder operation
  typedef enum logic [3:0] {
    OP_DIV  = 4'b0001,
    OP_DIVU = 4'b0010,
    OP_REM  = 4'b0100,
    OP_REMU = 4'b1000
  } rice_core_div_operation;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rice_core_div_ctrl_state;

  // Operand register contents; doubles as the result-cache tag
  typedef struct packed {
    rice_core_div_operation op;
    logic [XLEN-1:0]        rs1;
    logic [XLEN-1:0]        rs2;
  } rice_core_div_tag;

  function automatic logic is_signed(rice_core_div_operation op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem(rice_core_div_operation op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/rice_core_div.sv
// rtl/rice_core_div.sv - iterative radix-2 restoring divider, one quotient bit per cycle
module rice_core_div
  import rice_core_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic [XLEN-1:0]        i_rs1_value,
  input  logic [XLEN-1:0]        i_rs2_value,
  input  rice_core_div_operation i_div_operation,
  output logic                   o_result_valid,
  output logic [XLEN-1:0]        o_result
);

  localparam int CW = $clog2(XLEN);

  logic            busy;
  logic            done;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic            neg1;
  logic            neg2;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Magnitudes and one restoring step; operands stay stable for the whole run,
  // so the sign fix-up on the output can read them directly
  always_comb begin
    neg1    = is_signed(i_div_operation) && i_rs1_value[XLEN-1];
    neg2    = is_signed(i_div_operation) && i_rs2_value[XLEN-1];
    abs1    = neg1 ? -i_rs1_value : i_rs1_value;
    abs2    = neg2 ? -i_rs2_value : i_rs2_value;
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, dvs};
  end

  // Load on start, then XLEN shift/subtract steps; done pulses for one cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
    end else begin
      done <= 1'b0;
      if (i_valid) begin
        busy  <= 1'b1;
        count <= '0;
        quo   <= abs1;
        rem   <= '0;
        dvs   <= abs2;
      end else if (busy) begin
        rem   <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        quo   <= {quo[XLEN-2:0], ~diff[XLEN]};
        count <= count + 1'b1;
        if (count == CW'(XLEN - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // Quotient sign follows both operands, remainder sign follows the dividend
  always_comb begin
    o_result_valid = done;
    if (is_rem(i_div_operation)) o_result = neg1 ? -rem : rem;
    else                         o_result = (neg1 ^ neg2) ? -quo : quo;
  end

endmodule

// File: rtl/rice_core_div_ctrl.sv
// rtl/rice_core_div_ctrl.sv - request/result sequencing around the iterative divider
module rice_core_div_ctrl
  import rice_core_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [XLEN-1:0]        i_rs1_value,
  input  logic [XLEN-1:0]        i_rs2_value,
  input  rice_core_div_operation i_div_operation,
  input  logic                   i_flush,
  output logic                   o_result_valid,
  input  logic                   i_result_ready,
  output logic [XLEN-1:0]        o_result
);

  rice_core_div_ctrl_state state, state_next;
  rice_core_div_tag        req_tag, opnd_q, cache_tag;
  logic                    cache_valid;
  logic [XLEN-1:0]         cache_data;
  logic [XLEN-1:0]         result_q;
  logic                    start_q;
  logic                    div_valid;
  logic                    div_result_valid;
  logic [XLEN-1:0]         div_result;
  logic                    accept;
  logic                    div_by_zero;
  logic                    overflow;
  logic                    cache_hit;
  logic                    fast_path;
  logic                    capture;
  logic [XLEN-1:0]         fast_result;

  // Decide on accept whether the answer is known without running the divider
  always_comb begin
    req_tag.op  = i_div_operation;
    req_tag.rs1 = i_rs1_value;
    req_tag.rs2 = i_rs2_value;
    accept      = (state == IDLE) && i_valid && !i_flush;
    div_by_zero = (i_rs2_value == '0);
    overflow    = is_signed(i_div_operation) && (i_rs1_value == {1'b1, {(XLEN-1){1'b0}}})
                  && (i_rs2_value == '1);
    cache_hit   = cache_valid && (cache_tag == req_tag);
    fast_path   = div_by_zero || overflow || cache_hit;
    if (div_by_zero)   fast_result = is_rem(i_div_operation) ? i_rs1_value : '1;
    else if (overflow) fast_result = is_rem(i_div_operation) ? '0 : i_rs1_value;
    else               fast_result = cache_data;
    capture     = (state == BUSY) && div_result_valid && !i_flush;
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state; the divider cannot be aborted, so a flushed run drains first
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = fast_path ? DONE : BUSY;
      BUSY: begin
        if (div_result_valid) state_next = i_flush ? IDLE : DONE;
        else if (i_flush)     state_next = DRAIN;
      end
      DRAIN: if (div_result_valid) state_next = IDLE;
      DONE:  if (i_flush || i_result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs and the single-cycle divider start pulse
  always_comb begin
    o_ready        = (state == IDLE);
    o_result_valid = (state == DONE);
    div_valid      = (state == BUSY) && start_q;
    o_result       = result_q;
  end

  // Operand register, result register and single-entry result cache
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      start_q     <= 1'b0;
      opnd_q      <= '0;
      result_q    <= '0;
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
    end else begin
      start_q <= accept && !fast_path;
      if (accept) begin
        opnd_q <= req_tag;
        if (fast_path) result_q <= fast_result;
      end
      if (capture) begin
        result_q    <= div_result;
        cache_tag   <= opnd_q;
        cache_data  <= div_result;
        cache_valid <= 1'b1;
      end
    end
  end

  rice_core_div u_div (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_valid         (div_valid),
    .i_rs1_value     (opnd_q.rs1),
    .i_rs2_value     (opnd_q.rs2),
    .i_div_operation (opnd_q.op),
    .o_result_valid  (div_result_valid),
    .o_result        (div_result)
  );

endmodule

// File: tb/tb_rice_core_div_ctrl.sv
// tb/tb_rice_core_div_ctrl.sv - directed self-checking bench for rice_core_div_ctrl
module tb_rice_core_div_ctrl;
  import rice_core_pkg::*;

  logic                   clk;
  logic                   rst_n;
  logic                   i_valid;
  logic                   o_ready;
  logic [XLEN-1:0]        i_rs1_value;
  logic [XLEN-1:0]        i_rs2_value;
  rice_core_div_operation i_div_operation;
  logic                   i_flush;
  logic                   o_result_valid;
  logic                   i_result_ready;
  logic [XLEN-1:0]        o_result;

  int checks = 0;
  int errors = 0;
  int starts = 0;

  rice_core_div_ctrl dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_rs1_value     (i_rs1_value),
    .i_rs2_value     (i_rs2_value),
    .i_div_operation (i_div_operation),
    .i_flush         (i_flush),
    .o_result_valid  (o_result_valid),
    .i_result_ready  (i_result_ready),
    .o_result        (o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (dut.div_valid) starts++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge in IDLE, wait for the result, hand it off
  task automatic req(input string tag, input rice_core_div_operation op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res, input int exp_lat, input int exp_st);
    int lat;
    int s0;
    s0 = starts;
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    i_valid = 1'b1; i_div_operation = op; i_rs1_value = a; i_rs2_value = b;
    @(negedge clk);
    i_valid = 1'b0;
    lat = 1;
    while (!o_result_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, o_result, exp_res);
    i_result_ready = 1'b1;
    @(negedge clk);
    i_result_ready = 1'b0;
    chk({tag, "_starts"}, 32'(starts - s0), 32'(exp_st));
    chk({tag, "_idle"}, {30'd0, o_ready, o_result_valid}, 32'b10);
  endtask

  initial begin
    int s0;
    int ready_at;
    int seen_valid;
    int lat;
    rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_result_ready = 1'b0;
    i_rs1_value = '0; i_rs2_value = '0; i_div_operation = OP_DIVU;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(o_ready), 32'd1);
    chk("reset_valid", 32'(o_result_valid), 32'd0);

    req("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 35, 1);
    req("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 35, 1);
    req("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 1);
    req("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, 1);
    req("div_by0",    OP_DIV,  32'd123, 32'd0, 32'hFFFF_FFFF, 1, 0);
    req("remu_by0",   OP_REMU, 32'd5, 32'd0, 32'd5, 1, 0);
    req("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    req("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    req("divu_miss",  OP_DIVU, 32'd100, 32'd7, 32'd14, 35, 1);
    req("divu_hit",   OP_DIVU, 32'd100, 32'd7, 32'd14, 1, 0);
    req("div_otherop", OP_DIV, 32'd100, 32'd7, 32'd14, 35, 1);

    // Flush in cycle 10 of a divider run
    s0 = starts; ready_at = 0; seen_valid = 0;
    i_valid = 1'b1; i_div_operation = OP_DIVU; i_rs1_value = 32'd100; i_rs2_value = 32'd7;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      i_valid = 1'b0;
      i_flush = (c == 10);
      if (o_result_valid) seen_valid = 1;
      if (o_ready && ready_at == 0) ready_at = c;
    end
    i_flush = 1'b0;
    chk("flush_ready_at", 32'(ready_at), 32'd35);
    chk("flush_no_valid", 32'(seen_valid), 32'd0);
    chk("flush_starts", 32'(starts - s0), 32'd1);
    req("divu_after_flush", OP_DIVU, 32'd100, 32'd7, 32'd14, 35, 1);

    // Result backpressure for five cycles, handshake in cycle 40
    i_valid = 1'b1; i_div_operation = OP_DIVU; i_rs1_value = 32'd1000; i_rs2_value = 32'd3;
    @(negedge clk);
    i_valid = 1'b0;
    lat = 1;
    while (!o_result_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_lat", 32'(lat), 32'd35);
    for (int k = 0; k < 5; k++) begin
      chk("bp_result", o_result, 32'd333);
      chk("bp_flags", {30'd0, o_ready, o_result_valid}, 32'b01);
      @(negedge clk);
    end
    i_result_ready = 1'b1;
    @(negedge clk);
    i_result_ready = 1'b0;
    chk("bp_ready_41", {30'd0, o_ready, o_result_valid}, 32'b10);

    // Flush while a fast-path result sits in DONE
    i_valid = 1'b1; i_div_operation = OP_DIV; i_rs1_value = 32'd5; i_rs2_value = 32'd0;
    @(negedge clk);
    i_valid = 1'b0;
    chk("done_flush_res", o_result, 32'hFFFF_FFFF);
    chk("done_flush_valid", 32'(o_result_valid), 32'd1);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    chk("done_flush_idle", {30'd0, o_ready, o_result_valid}, 32'b10);

    // Flush wins over a simultaneous request in IDLE
    s0 = starts;
    i_valid = 1'b1; i_flush = 1'b1; i_div_operation = OP_DIVU; i_rs1_value = 32'd9; i_rs2_value = 32'd4;
    @(negedge clk);
    i_valid = 1'b0; i_flush = 1'b0;
    chk("idle_flush_ready", {30'd0, o_ready, o_result_valid}, 32'b10);
    @(negedge clk);
    chk("idle_flush_starts", 32'(starts - s0), 32'd0);

    // Asynchronous reset mid-operation clears state, divider and cache
    i_valid = 1'b1; i_div_operation = OP_DIVU; i_rs1_value = 32'd77; i_rs2_value = 32'd5;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", 32'(o_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req("divu_after_reset", OP_DIVU, 32'd100, 32'd7, 32'd14, 35, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
